// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   Conditional-branch direction predictor built from a table of 2-bit saturating counters.
//   D stage reads the table and requests a fetch redirect to PC+imm when the entry predicts taken.
//   The prediction is carried to E, where it is compared with the resolved direction. A wrong
//   prediction raises a mispredict flush with the recovery PC. Resolved branches then train the
//   table and update the perf counters.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_pc_d, i_imm_d      D-stage PC and sign-extended B-type immediate
//   i_branch_d           D instruction is a conditional branch
//   i_stall_e, i_flush_e hold / bubble the D/E prediction register
//   i_branch_e           E instruction is a conditional branch
//   i_branch_taken_e     resolved direction in E
//   i_pc_e               PC of the E instruction
//   i_pc_target_e        resolved branch target in E
//   o_pred_redirect_d    fetch must redirect to o_pred_target_d
//   o_pred_target_d      i_pc_d + i_imm_d
//   o_pred_taken_e       prediction carried for the E instruction
//   o_mispredict_e       flush F/D and redirect fetch to o_recover_pc_e
//   o_recover_pc_e       correct next PC for the E instruction
//   o_branch_cnt         branches retired through E
//   o_mispredict_cnt     mispredicted branches
module branch_predictor_bht #(
    parameter int unsigned INDEX_BITS   = 6,
    parameter logic [1:0]  COUNTER_INIT = 2'b01,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_pc_d,
    input  logic [31:0]      i_imm_d,
    input  logic             i_branch_d,
    input  logic             i_stall_e,
    input  logic             i_flush_e,
    input  logic             i_branch_e,
    input  logic             i_branch_taken_e,
    input  logic [31:0]      i_pc_e,
    input  logic [31:0]      i_pc_target_e,
    output logic             o_pred_redirect_d,
    output logic [31:0]      o_pred_target_d,
    output logic             o_pred_taken_e,
    output logic             o_mispredict_e,
    output logic [31:0]      o_recover_pc_e,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int unsigned Entries = 1 << INDEX_BITS;

    logic [1:0]            bht_q [Entries];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] idx_e_q;
    logic                  pred_taken_e_q;
    logic [CNT_W-1:0]      branch_cnt_q;
    logic [CNT_W-1:0]      mispredict_cnt_q;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_nxt;
    logic                  train;

    // D stage
    always_comb begin
        rd_idx            = i_pc_d[INDEX_BITS+1:2];
        o_pred_redirect_d = i_branch_d & bht_q[rd_idx][1];
        o_pred_target_d   = i_pc_d + i_imm_d;
    end

    // E stage
    always_comb begin
        o_pred_taken_e = pred_taken_e_q;
        o_mispredict_e = i_branch_e & (i_branch_taken_e ^ pred_taken_e_q) & ~i_rst;
        o_recover_pc_e = (i_branch_e & i_branch_taken_e) ? i_pc_target_e : i_pc_e + 32'd4;
        // A stalled branch is counted/trained only on the cycle it leaves E.
        train          = i_branch_e & ~i_stall_e & ~i_rst;
    end

    // Saturating counter update for the entry captured with the E instruction
    always_comb begin
        ctr_cur = bht_q[idx_e_q];
        ctr_nxt = ctr_cur;
        if (i_branch_taken_e) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < Entries; i++) bht_q[i] <= COUNTER_INIT;
            pred_taken_e_q   <= 1'b0;
            idx_e_q          <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (i_flush_e) begin
                pred_taken_e_q <= 1'b0;
                idx_e_q        <= '0;
            end else if (!i_stall_e) begin
                pred_taken_e_q <= o_pred_redirect_d;
                idx_e_q        <= rd_idx;
            end
            // D reads in this cycle still see the old entry; no bypass.
            if (train) begin
                bht_q[idx_e_q] <= ctr_nxt;
                branch_cnt_q   <= branch_cnt_q + CNT_W'(1);
                if (o_mispredict_e) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_branch_cnt     = branch_cnt_q;
    assign o_mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_d, imm_d, pc_e, target_e;
    logic        branch_d, stall_e, flush_e, branch_e, taken_e;

    logic        redirect, pred_e, mp;
    logic [31:0] target, recover;
    logic [15:0] bcnt, mcnt;

    logic        redirect4, pred_e4, mp4;
    logic [31:0] target4, recover4;
    logic [3:0]  bcnt4, mcnt4;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] exp;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .i_clk(clk), .i_rst(rst), .i_pc_d(pc_d), .i_imm_d(imm_d), .i_branch_d(branch_d),
        .i_stall_e(stall_e), .i_flush_e(flush_e), .i_branch_e(branch_e),
        .i_branch_taken_e(taken_e), .i_pc_e(pc_e), .i_pc_target_e(target_e),
        .o_pred_redirect_d(redirect), .o_pred_target_d(target), .o_pred_taken_e(pred_e),
        .o_mispredict_e(mp), .o_recover_pc_e(recover), .o_branch_cnt(bcnt),
        .o_mispredict_cnt(mcnt)
    );

    branch_predictor_bht #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_pc_d(pc_d), .i_imm_d(imm_d), .i_branch_d(branch_d),
        .i_stall_e(stall_e), .i_flush_e(flush_e), .i_branch_e(branch_e),
        .i_branch_taken_e(taken_e), .i_pc_e(pc_e), .i_pc_target_e(target_e),
        .o_pred_redirect_d(redirect4), .o_pred_target_d(target4), .o_pred_taken_e(pred_e4),
        .o_mispredict_e(mp4), .o_recover_pc_e(recover4), .o_branch_cnt(bcnt4),
        .o_mispredict_cnt(mcnt4)
    );

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_d = 32'h100; imm_d = 32'h40; branch_d = 1'b1;
        stall_e = 1'b0; flush_e = 1'b0; branch_e = 1'b1; taken_e = 1'b1;
        pc_e = 32'h100; target_e = 32'h140;
        tick();
        sb.push_back(32'h0);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(mp) !== exp) begin errors++; $display("FAIL rst_mispredict: got %0h want %0h", mp, exp); end
        tick();
        rst = 1'b0; branch_e = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if (32'(pred_e) !== exp) begin errors++; $display("FAIL rst_pred_e: got %0h want %0h", pred_e, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL rst_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL rst_mcnt: got %0h want %0h", mcnt, exp); end
    endtask

    task automatic test_predict_d();
        pc_d = 32'h100; imm_d = 32'h40; branch_d = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h140);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL d_redirect: got %0h want %0h", redirect, exp); end
        exp = sb.pop_front(); checks++;
        if (target !== exp) begin errors++; $display("FAIL d_target: got %0h want %0h", target, exp); end
        pc_d = 32'hFFFF_FFF0; imm_d = 32'h20; branch_d = 1'b0;
        sb.push_back(32'h10);
        #1;
        exp = sb.pop_front(); checks++;
        if (target !== exp) begin errors++; $display("FAIL d_target_wrap: got %0h want %0h", target, exp); end
        pc_d = 32'h100; imm_d = 32'h40; branch_d = 1'b1;
    endtask

    task automatic test_train_taken();
        // Entry 0: 01 -> 10 -> 11 -> 11; D reads the old value during each update
        branch_e = 1'b1; taken_e = 1'b1; pc_e = 32'h100; target_e = 32'h140;
        sb.push_back(32'h1); sb.push_back(32'h0);
        sb.push_back(32'h1); sb.push_back(32'h1);
        sb.push_back(32'h0); sb.push_back(32'h1);
        for (int k = 0; k < 3; k++) begin
            #2;
            exp = sb.pop_front(); checks++;
            if (32'(mp) !== exp) begin errors++; $display("FAIL train_mp[%0d]: got %0h want %0h", k, mp, exp); end
            exp = sb.pop_front(); checks++;
            if (32'(redirect) !== exp) begin errors++; $display("FAIL train_redirect[%0d]: got %0h want %0h", k, redirect, exp); end
            tick();
        end
        branch_e = 1'b0;
        sb.push_back(32'd3); sb.push_back(32'd2); sb.push_back(32'h1);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL train_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL train_mcnt: got %0h want %0h", mcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL train_redirect_after: got %0h want %0h", redirect, exp); end
    endtask

    task automatic test_mispredict_not_taken();
        // Predicted taken, resolves not-taken twice: entry 11 -> 10 -> 01
        branch_e = 1'b1; taken_e = 1'b0; pc_e = 32'h100;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(32'h1); sb.push_back(32'h104);
            #2;
            exp = sb.pop_front(); checks++;
            if (32'(mp) !== exp) begin errors++; $display("FAIL nt_mp[%0d]: got %0h want %0h", k, mp, exp); end
            exp = sb.pop_front(); checks++;
            if (recover !== exp) begin errors++; $display("FAIL nt_recover[%0d]: got %0h want %0h", k, recover, exp); end
            tick();
        end
        sb.push_back(32'd5); sb.push_back(32'd4); sb.push_back(32'h0);
        branch_e = 1'b0;
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL nt_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL nt_mcnt: got %0h want %0h", mcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL nt_redirect: got %0h want %0h", redirect, exp); end
    endtask

    task automatic test_mispredict_taken();
        // Non-branch in E while a taken prediction is carried: no mispredict
        sb.push_back(32'h1); sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if (32'(pred_e) !== exp) begin errors++; $display("FAIL t_pred_e: got %0h want %0h", pred_e, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mp) !== exp) begin errors++; $display("FAIL t_nonbranch_mp: got %0h want %0h", mp, exp); end
        tick();
        branch_e = 1'b1; taken_e = 1'b1; target_e = 32'h140;
        sb.push_back(32'h1); sb.push_back(32'h140);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(mp) !== exp) begin errors++; $display("FAIL t_mp: got %0h want %0h", mp, exp); end
        exp = sb.pop_front(); checks++;
        if (recover !== exp) begin errors++; $display("FAIL t_recover: got %0h want %0h", recover, exp); end
        tick();
        taken_e = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h104);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(mp) !== exp) begin errors++; $display("FAIL t_correct_mp: got %0h want %0h", mp, exp); end
        exp = sb.pop_front(); checks++;
        if (recover !== exp) begin errors++; $display("FAIL t_correct_recover: got %0h want %0h", recover, exp); end
        tick();
        branch_e = 1'b0;
        sb.push_back(32'd7); sb.push_back(32'd5);
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL t_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL t_mcnt: got %0h want %0h", mcnt, exp); end
    endtask

    task automatic test_stall();
        // pred_e=1, entry0=01, bcnt=7. A load would pull in redirect=0.
        branch_d = 1'b0; stall_e = 1'b1; branch_e = 1'b1; taken_e = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            sb.push_back(32'h1); sb.push_back(32'd7);
            exp = sb.pop_front(); checks++;
            if (32'(pred_e) !== exp) begin errors++; $display("FAIL stall_pred_e[%0d]: got %0h want %0h", k, pred_e, exp); end
            exp = sb.pop_front(); checks++;
            if (32'(bcnt) !== exp) begin errors++; $display("FAIL stall_bcnt[%0d]: got %0h want %0h", k, bcnt, exp); end
        end
        stall_e = 1'b0;
        tick();
        sb.push_back(32'h0); sb.push_back(32'd8);
        exp = sb.pop_front(); checks++;
        if (32'(pred_e) !== exp) begin errors++; $display("FAIL stall_rel_pred_e: got %0h want %0h", pred_e, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL stall_rel_bcnt: got %0h want %0h", bcnt, exp); end
        // One not-taken step must bring a single-trained entry (10) back to 01
        branch_d = 1'b1; taken_e = 1'b0;
        tick();
        branch_e = 1'b0;
        sb.push_back(32'h0);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL stall_once_redirect: got %0h want %0h", redirect, exp); end
    endtask

    task automatic test_flush_alias();
        branch_e = 1'b1; taken_e = 1'b1;  // entry0 01 -> 10
        tick();
        branch_e = 1'b0; pc_d = 32'h100; branch_d = 1'b1;
        tick();
        sb.push_back(32'h1);
        exp = sb.pop_front(); checks++;
        if (32'(pred_e) !== exp) begin errors++; $display("FAIL load_pred_e: got %0h want %0h", pred_e, exp); end
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        sb.push_back(32'h0);
        exp = sb.pop_front(); checks++;
        if (32'(pred_e) !== exp) begin errors++; $display("FAIL flush_pred_e: got %0h want %0h", pred_e, exp); end
        pc_d = 32'h200;
        sb.push_back(32'h1); sb.push_back(32'h240);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL alias_redirect: got %0h want %0h", redirect, exp); end
        exp = sb.pop_front(); checks++;
        if (target !== exp) begin errors++; $display("FAIL alias_target: got %0h want %0h", target, exp); end
        pc_d = 32'h104;
        sb.push_back(32'h0);
        #1;
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL nonalias_redirect: got %0h want %0h", redirect, exp); end
    endtask

    task automatic test_reset_mid();
        tick();
        rst = 1'b1; branch_e = 1'b1; taken_e = 1'b1; pc_d = 32'h100;
        sb.push_back(32'h0);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(mp) !== exp) begin errors++; $display("FAIL mid_rst_mp: got %0h want %0h", mp, exp); end
        tick();
        rst = 1'b0; branch_e = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
        #2;
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL mid_rst_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL mid_rst_mcnt: got %0h want %0h", mcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(redirect) !== exp) begin errors++; $display("FAIL mid_rst_redirect: got %0h want %0h", redirect, exp); end
    endtask

    task automatic test_wrap();
        branch_d = 1'b0; branch_e = 1'b1; taken_e = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        sb.push_back(32'd15); sb.push_back(32'd15);
        exp = sb.pop_front(); checks++;
        if (32'(bcnt4) !== exp) begin errors++; $display("FAIL wrap_bcnt4_15: got %0h want %0h", bcnt4, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL wrap_bcnt_15: got %0h want %0h", bcnt, exp); end
        tick();
        branch_e = 1'b0;
        sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd16); sb.push_back(32'd16);
        exp = sb.pop_front(); checks++;
        if (32'(bcnt4) !== exp) begin errors++; $display("FAIL wrap_bcnt4: got %0h want %0h", bcnt4, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt4) !== exp) begin errors++; $display("FAIL wrap_mcnt4: got %0h want %0h", mcnt4, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(bcnt) !== exp) begin errors++; $display("FAIL wrap_bcnt: got %0h want %0h", bcnt, exp); end
        exp = sb.pop_front(); checks++;
        if (32'(mcnt) !== exp) begin errors++; $display("FAIL wrap_mcnt: got %0h want %0h", mcnt, exp); end
    endtask

    initial begin
        rst = 1'b1; pc_d = '0; imm_d = '0; pc_e = '0; target_e = '0;
        branch_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0; branch_e = 1'b0; taken_e = 1'b0;
        tick();
        test_reset();
        test_predict_d();
        test_train_taken();
        tick();
        test_mispredict_not_taken();
        test_mispredict_taken();
        test_stall();
        test_flush_alias();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
